cla_addsub_pipe: RTL
====================

Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the FPU datapath. It is the successor to the fixed 16-bit combinational CLA.
- Operand width and pipeline depth are generics.
- Adds a subtract mode and signed status flags.
- Uses a valid/ready handshake with backpressure.
- Feeds the CSA/shifter stages, for example mantissa add and exponent difference.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4*STAGES.
STAGES, 2, number of pipeline stages (1..4); equals latency in cycles.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand set presented.
in_ready  output  1  block accepts operands this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_ci  input  1  carry-in (borrow-in when subtracting).
in_sub  input  1  0 = A+B+ci; 1 = A-B-ci.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_sum  output  WIDTH  result.
out_co  output  1  raw carry-out of the MSB adder.
out_ovf  output  1  two's-complement signed overflow.
out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (async assert, sync-released by the top level):
  - all stage valid bits clear; out_valid=0;
  - out_sum=0, out_co=0, out_ovf=0, out_zero=0;
  - any in-flight operations are discarded.
- Arithmetic:
  - B' = in_b ^ {WIDTH{in_sub}}; c0 = in_ci ^ in_sub.
  - Result is A + B' + c0, modulo 2^WIDTH.
  - out_co = carry out of bit WIDTH-1 (unsigned borrow = ~out_co when in_sub=1).
  - out_ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (k = 0..STAGES-1) computes sum bits [k*SEG +: SEG] with 4-bit CLA groups and a group-level lookahead.
  - Carry-in for stage k is the registered carry from stage k-1.
  - Unused upper operand bits and completed lower sum bits travel skewed in the pipeline registers.
- Latency: exactly STAGES cycles from the accepting edge to out_valid with no stall.
- Throughput: one operation per cycle.
- Handshake:
  - Global advance signal: adv = !out_valid || out_ready.
  - in_ready = adv.
  - Transfer occurs when in_valid && in_ready; out consumption occurs when out_valid && out_ready.
  - When adv=0, every stage register holds, including bubbles; bubbles are not collapsed.
  - Input is registered only on a transfer; otherwise a bubble (valid=0) enters stage 0.
- Output data is stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO; there is no reordering and no loss.
- Flags are computed in the final stage on the full result; out_zero is evaluated on the post-saturation value.
- in_valid with adv=0: nothing is captured; the source must hold its operands.
- Reset asserted mid-operation: out_valid drops asynchronously; post-reset output contains no stale results.

Optional Feature:
CLA_ADDSUB_SAT_EN
- Defined: when out_ovf=1, out_sum clamps to the signed extreme.
  - 2^(WIDTH-1)-1 if A[MSB]=0;
  - -2^(WIDTH-1) if A[MSB]=1.
  - out_ovf still reports 1; out_co is unchanged (raw).
- Undefined: out_sum is the wrapped result. No clamp logic is synthesised.

Decomposition:
- Package cla_pkg:
  - localparam CLA_GRP = 4;
  - function clog2;
  - typedef of per-stage pipeline record (valid, carry, partial sum, remaining A/B', sub-adjusted MSB signs);
  - function computing ovf from the MSB signs.
- Sub-module cla_seg:
  - SEG-bit combinational CLA built from CLA_GRP groups with P/G lookahead;
  - ports a, b, ci, s, co, msb_carry_in;
  - instantiated once per stage.

Test Plan:
- WIDTH=16, STAGES=2: A=AAAA, B=5555, ci=1, sub=0 -> after 2 cycles sum=0000, co=1, zero=1, ovf=0.
- A=AAAA, B=5555, ci=0 -> sum=FFFF, co=0, zero=0; next-cycle back-to-back A=1552, B=713 -> sum=0x08D9 one cycle later.
- sub=1: A=0005, B=0007, ci=0 -> sum=FFFE, co=0, ovf=0. A=8000, B=0001 -> sum=7FFF, ovf=1 (8000 with CLA_ADDSUB_SAT_EN).
- A=7FFF, B=0001, sub=0 -> sum=8000, ovf=1; with CLA_ADDSUB_SAT_EN sum=7FFF, ovf=1.
- Three back-to-back inputs, out_ready low for 5 cycles -> in_ready=0 while out_valid&&!out_ready, out_sum held stable, all three results emerge in order after release, none lost or duplicated.
- rst_n pulsed low with 2 operations in flight -> out_valid=0 immediately; after release the first output is the first post-reset input, at latency STAGES.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, pipeline control record and flag helpers for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned CLA_GRP = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  // Control part of a stage record; the data part depends on WIDTH and
  // is declared next to it in the top level.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } cla_ctl_t;

  // Sum MSB is a^b'^carry_in, so with equal operand signs the result sign
  // flips exactly when the carry into the MSB differs from that sign.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb,
                                  input logic msb_ci);
    return (a_msb == b_msb) && (msb_ci != a_msb);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// SEG-bit combinational carry-lookahead adder: 4-bit P/G groups with a
// group-level lookahead from the segment carry-in.
module cla_seg
  import cla_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           msb_carry_in
);

  localparam int unsigned NGRP = SEG / CLA_GRP;

  logic [SEG-1:0]  g;
  logic [SEG-1:0]  p;
  logic [SEG-1:0]  c;
  logic [NGRP-1:0] grp_g;
  logic [NGRP-1:0] grp_p;
  logic [NGRP:0]   grp_c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '1;
    grp_c = '0;
    c     = '0;
    for (int unsigned j = 0; j < NGRP; j++) begin
      for (int unsigned i = 0; i < CLA_GRP; i++) begin
        grp_g[j] = g[j*CLA_GRP+i] | (p[j*CLA_GRP+i] & grp_g[j]);
        grp_p[j] = grp_p[j] & p[j*CLA_GRP+i];
      end
    end
    // Every group carry is expanded from ci directly, not chained group to group.
    grp_c[0] = ci;
    for (int unsigned j = 1; j <= NGRP; j++) begin
      grp_c[j] = ci;
      for (int unsigned i = 0; i < j; i++) begin
        grp_c[j] = grp_g[i] | (grp_p[i] & grp_c[j]);
      end
    end
    for (int unsigned j = 0; j < NGRP; j++) begin
      c[j*CLA_GRP] = grp_c[j];
      for (int unsigned i = 0; i < CLA_GRP - 1; i++) begin
        c[j*CLA_GRP+i+1] = g[j*CLA_GRP+i] | (p[j*CLA_GRP+i] & c[j*CLA_GRP+i]);
      end
    end
  end

  assign s            = p ^ c;
  assign co           = grp_c[NGRP];
  assign msb_carry_in = c[SEG-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor with valid/ready backpressure and signed
// flags. Define CLA_ADDSUB_SAT_EN to clamp overflowing results.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned NREG = (STAGES > 1) ? STAGES - 1 : 1;

  // word: remaining A in the low bits, finished sum segments entering from
  // the top; b: remaining B' shifted down one segment per stage.
  typedef struct packed {
    cla_ctl_t         ctl;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] b;
  } stage_t;

  typedef struct packed {
    logic             valid;
    logic             co;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] sum;
  } out_t;

  logic             adv;
  logic             in_fire;
  logic [WIDTH-1:0] b_x;
  stage_t           in_rec;
  stage_t           st_in   [STAGES];
  stage_t           st_out  [STAGES];
  logic [SEG-1:0]   seg_s   [STAGES];
  logic             seg_co  [STAGES];
  logic             seg_mci [STAGES];
  stage_t           pipe_d  [NREG];
  stage_t           pipe_q  [NREG];
  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;
  out_t             out_d;
  out_t             out_q;

  assign adv     = !out_q.valid || out_ready;
  assign in_fire = in_valid && adv;
  assign b_x     = in_b ^ {WIDTH{in_sub}};

  always_comb begin
    in_rec = '0;
    if (in_fire) begin
      in_rec.ctl.valid = 1'b1;
      in_rec.ctl.carry = in_ci ^ in_sub;
      in_rec.ctl.a_msb = in_a[WIDTH-1];
      in_rec.ctl.b_msb = b_x[WIDTH-1];
      in_rec.word      = in_a;
      in_rec.b         = b_x;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src_in
      assign st_in[k] = in_rec;
    end else begin : g_src_pipe
      assign st_in[k] = pipe_q[k-1];
    end

    cla_seg #(.SEG(SEG)) u_seg (
      .a            (st_in[k].word[SEG-1:0]),
      .b            (st_in[k].b[SEG-1:0]),
      .ci           (st_in[k].ctl.carry),
      .s            (seg_s[k]),
      .co           (seg_co[k]),
      .msb_carry_in (seg_mci[k])
    );

    assign st_out[k] = '{
      ctl:  '{valid: st_in[k].ctl.valid, carry: seg_co[k],
              a_msb: st_in[k].ctl.a_msb, b_msb: st_in[k].ctl.b_msb},
      word: (st_in[k].word >> SEG) | (WIDTH'(seg_s[k]) << (WIDTH - SEG)),
      b:    st_in[k].b >> SEG
    };
  end

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      pipe_d[i] = adv ? st_out[i] : pipe_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) pipe_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    fin_ovf = ovf_of(st_out[LAST].ctl.a_msb, st_out[LAST].ctl.b_msb, seg_mci[LAST]);
    fin_sum = st_out[LAST].word;
`ifdef CLA_ADDSUB_SAT_EN
    if (fin_ovf) begin
      fin_sum = st_out[LAST].ctl.a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    out_d = out_q;
    if (adv) begin
      out_d.valid = st_out[LAST].ctl.valid;
      out_d.co    = st_out[LAST].ctl.carry;
      out_d.ovf   = fin_ovf;
      out_d.zero  = st_out[LAST].ctl.valid && (fin_sum == '0);
      out_d.sum   = fin_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign in_ready  = adv;
  assign out_valid = out_q.valid;
  assign out_sum   = out_q.sum;
  assign out_co    = out_q.co;
  assign out_ovf   = out_q.ovf;
  assign out_zero  = out_q.zero;

endmodule
